// File: rtl/aha_clock_select_ctrl_pkg.sv
// aha_clock_select_ctrl_pkg: shared ratio indices, FSM state encoding and one-hot decode for the clock select sequencer and mux
package aha_clock_select_ctrl_pkg;
  localparam int DIV1    = 0;
  localparam int DIV2    = 1;
  localparam int DIV4    = 2;
  localparam int DIV8    = 3;
  localparam int DIV16   = 4;
  localparam int DIV32   = 5;
  localparam int NUM_DIV = 6;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRAIN, ST_ALIGN} state_e;
  function automatic logic [NUM_DIV-1:0] onehot(input logic [2:0] idx);
    return NUM_DIV'(1) << idx;
  endfunction
endpackage

// File: rtl/aha_clock_select_ctrl_if.sv
// aha_clock_select_ctrl_if: divider strobes, ratio-change request handshake and clock mux/gate controls
//   master: requester side (drives div_en, req_valid, req_sel)
//   slave : sequencer side (drives req_ready, clk_sel, clk_gate_en, busy, done, err)
interface aha_clock_select_ctrl_if;
  import aha_clock_select_ctrl_pkg::*;
  logic [NUM_DIV-1:0] div_en;
  logic               req_valid;
  logic [2:0]         req_sel;
  logic               req_ready;
  logic [NUM_DIV-1:0] clk_sel;
  logic               clk_gate_en;
  logic               busy;
  logic               done;
  logic               err;
  modport master (output div_en, req_valid, req_sel,
                  input  req_ready, clk_sel, clk_gate_en, busy, done, err);
  modport slave  (input  div_en, req_valid, req_sel,
                  output req_ready, clk_sel, clk_gate_en, busy, done, err);
endinterface

// File: rtl/aha_clock_select_ctrl.sv
// aha_clock_select_ctrl: glitch-free divide-ratio switchover sequencer (gate, drain, move select, align, ungate)
//   CLK   : divider source clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : slave side of aha_clock_select_ctrl_if (strobes, request handshake, select/gate/status outputs)
module aha_clock_select_ctrl
  import aha_clock_select_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int RESET_SEL    = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  aha_clock_select_ctrl_if.slave bus
);
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         tgt_q, tgt_d;
  logic [NUM_DIV-1:0] clk_sel_q, clk_sel_d;
  logic               gate_q, gate_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      tgt_q     <= 3'(RESET_SEL);
      clk_sel_q <= onehot(3'(RESET_SEL));
      gate_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      clk_sel_q <= clk_sel_d;
      gate_q    <= gate_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    clk_sel_d = clk_sel_q;
    gate_d    = gate_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_INIT:
        if (bus.div_en[RESET_SEL]) begin
          gate_d  = 1'b1;
          state_d = ST_IDLE;
        end
      ST_IDLE:
        if (bus.req_valid) begin
          if (bus.req_sel >= 3'(NUM_DIV)) err_d = 1'b1;
          else if (onehot(bus.req_sel) == clk_sel_q) done_d = 1'b1;
          else begin
            tgt_d   = bus.req_sel;
            cnt_d   = 4'(DRAIN_CYCLES - 1);
            gate_d  = 1'b0;
            state_d = ST_DRAIN;
          end
        end
      ST_DRAIN:
        if (cnt_q == '0) begin
          clk_sel_d = onehot(tgt_q);
          state_d   = ST_ALIGN;
        end else cnt_d = cnt_q - 4'd1;
      ST_ALIGN:
        if (bus.div_en[tgt_q]) begin
          gate_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      default: state_d = ST_INIT;
    endcase
  end
  assign bus.req_ready   = state_q == ST_IDLE;
  assign bus.busy        = state_q != ST_IDLE;
  assign bus.clk_sel     = clk_sel_q;
  assign bus.clk_gate_en = gate_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_aha_clock_select_ctrl.sv
// tb_aha_clock_select_ctrl: randomized and directed checks of the clock select sequencer against a timestamp-based reference model
module tb_aha_clock_select_ctrl;
  localparam int D  = 4;
  localparam int RS = 0;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  aha_clock_select_ctrl_if bus();
  aha_clock_select_ctrl #(.DRAIN_CYCLES(D), .RESET_SEL(RS)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));
  always #5 CLK = ~CLK;
  int n_vec = 0, n_bad = 0, cyc = 0;
  bit in_rst = 1'b1, act = 1'b0, init = 1'b0, acc = 1'b0;
  int m_sel = RS, t_new = RS, t_sw = 0, t_end = 0, pd = -1, pe = -1;
  logic [5:0] prev_sel;
  logic prev_gate;
  bit prev_ok = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [5:0] oh(input int i);
    logic [5:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction
  function automatic logic [5:0] div_at(input int c);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = (c % (1 << k)) == 0;
    return r;
  endfunction
  function automatic int first_strobe(input int a, input int k);
    int x;
    x = a;
    while (x % (1 << k) != 0) x++;
    return x;
  endfunction
  task automatic check_outputs();
    logic [5:0] es;
    logic eg, er, eb, ed, ee;
    if (in_rst) begin
      es = oh(RS); eg = 0; er = 0; eb = 1; ed = 0; ee = 0;
    end else if (act && cyc == t_end) begin
      es = oh(t_new); eg = 1; er = 1; eb = 0; ed = !init; ee = 0;
    end else if (act) begin
      es = oh(cyc >= t_sw ? t_new : m_sel); eg = 0; er = 0; eb = 1; ed = 0; ee = 0;
    end else begin
      es = oh(m_sel); eg = 1; er = 1; eb = 0; ed = cyc == pd; ee = cyc == pe;
    end
    chk("clk_sel", 32'(bus.clk_sel), 32'(es));
    chk("gate", 32'(bus.clk_gate_en), 32'(eg));
    chk("ready", 32'(bus.req_ready), 32'(er));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("done", 32'(bus.done), 32'(ed));
    chk("err", 32'(bus.err), 32'(ee));
    if (!in_rst && prev_ok && bus.clk_sel !== prev_sel)
      chk("sel_while_gated", 32'({prev_gate, bus.clk_gate_en}), 32'(0));
    if (!in_rst && act && cyc == t_end) begin
      act = 0;
      m_sel = t_new;
    end
    prev_ok = !in_rst;
    prev_sel = bus.clk_sel;
    prev_gate = bus.clk_gate_en;
  endtask
  task automatic cycle(input bit v, input logic [2:0] s);
    bus.req_valid = v;
    bus.req_sel = s;
    acc = 0;
    if (v && !act && !in_rst) begin
      acc = 1;
      if (s > 5) pe = cyc + 1;
      else if (int'(s) == m_sel) pd = cyc + 1;
      else begin
        act = 1; init = 0; t_new = int'(s);
        t_sw = cyc + D + 1;
        t_end = first_strobe(cyc + D + 1, int'(s)) + 1;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    bus.div_en = div_at(cyc);
    check_outputs();
  endtask
  task automatic reset_now();
    #2;
    RESET = 1'b1;
    in_rst = 1; act = 0; pd = -1; pe = -1; m_sel = RS;
    bus.req_valid = 0;
    #1;
    check_outputs();
  endtask
  task automatic release_rst();
    RESET = 1'b0;
    in_rst = 0; act = 1; init = 1; t_new = RS; m_sel = RS;
    t_sw = cyc;
    t_end = first_strobe(cyc, RS) + 1;
  endtask
  task automatic req(input logic [2:0] s);
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle(1'b1, s);
      got = acc;
    end
    if (!got) chk("accept_timeout", 32'(0), 32'(1));
    bus.req_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && act; i++) cycle(1'b0, 3'd0);
    chk("idle_timeout", 32'(act), 32'(0));
  endtask
  initial begin
    bit p;
    logic [2:0] ps;
    bus.req_valid = 0;
    bus.req_sel = 0;
    bus.div_en = div_at(0);
    #1 RESET = 1'b1;
    #1 check_outputs();
    repeat (3) cycle(1'b0, 3'd0);
    release_rst();
    repeat (3) cycle(1'b0, 3'd0);
    req(3'd3);
    wait_idle();
    req(3'd0);
    wait_idle();
    req(3'd0);
    cycle(1'b0, 3'd0);
    req(3'd7);
    cycle(1'b0, 3'd0);
    req(3'd6);
    req(3'd0);
    cycle(1'b0, 3'd0);
    req(3'd5);
    req(3'd1);
    wait_idle();
    chk("b2b_sel", 32'(bus.clk_sel), 32'(6'b000010));
    req(3'd2);
    repeat (2) cycle(1'b0, 3'd0);
    reset_now();
    repeat (2) cycle(1'b0, 3'd0);
    release_rst();
    repeat (3) cycle(1'b0, 3'd0);
    req(3'd5);
    for (int i = 0; i < 50 && act && cyc < t_sw; i++) cycle(1'b0, 3'd0);
    reset_now();
    repeat (2) cycle(1'b0, 3'd0);
    release_rst();
    repeat (3) cycle(1'b0, 3'd0);
    p = 0;
    ps = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p && $urandom_range(0, 2) == 0) begin
        p = 1;
        ps = 3'($urandom_range(0, 7));
      end
      cycle(p, ps);
      if (acc) p = 0;
      if ($urandom_range(0, 149) == 0) begin
        reset_now();
        cycle(1'b0, 3'd0);
        release_rst();
        p = 0;
      end
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
